// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comp_pkg
// Description : Shared constants, types and helpers for the sign-magnitude to
//               two's-complement arbiter slice (comp_conv_arb, sm2tc_unit).
//               Optional feature macro used by the slice: COMP_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package comp_pkg;

    // Default data width: one sign bit plus DW-1 magnitude bits.
    localparam int c_dw = 8;

    // Sign-magnitude "negative zero" at the default width.
    localparam logic [c_dw-1:0] c_neg_zero = 8'h80;

    // One sign-magnitude byte at the default width.
    typedef logic [c_dw-1:0] sm_byte_t;

    // Ceiling log2, used to size requester IDs. clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : comp_pkg
`default_nettype wire

// File: rtl/sm2tc_unit.sv
`default_nettype none
// ============================================================================
// Module      : sm2tc_unit
// Description : Purely combinational sign-magnitude to two's-complement
//               converter of width DW.
//               Positive bytes pass through unchanged; negative bytes become
//               {1, (~mag + 1) truncated to DW-1 bits}, so negative zero
//               (sign=1, mag=0) maps back onto itself.
// Ports       : i_sm  [DW-1:0]  sign-magnitude input
//               o_tc  [DW-1:0]  two's-complement result
// Revision    : 1.0 - initial release
// ============================================================================
module sm2tc_unit
    import comp_pkg::*;
#(
    parameter int DW = c_dw
) (
    input  logic [DW-1:0] i_sm,
    output logic [DW-1:0] o_tc
);

    localparam logic [DW-2:0] c_one = (DW-1)'(1);

    logic [DW-2:0] w_mag;
    logic [DW-2:0] w_neg_mag;

    assign w_mag     = i_sm[DW-2:0];
    // Carry out of the magnitude field is dropped on purpose: this is what
    // turns negative zero back into {1, 0...0}.
    assign w_neg_mag = ~w_mag + c_one;
    assign o_tc      = i_sm[DW-1] ? {1'b1, w_neg_mag} : i_sm;

endmodule : sm2tc_unit
`default_nettype wire

// File: rtl/comp_conv_arb.sv
`default_nettype none
// ============================================================================
// Module      : comp_conv_arb
// Description : Round-robin arbiter sharing one sign-magnitude to
//               two's-complement converter among NREQ requesters. The
//               winner's byte is converted and registered, then presented on
//               a single valid/ready output channel together with the
//               requester ID. Drain and refill can happen in the same cycle.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               req_valid [NREQ]         per-requester valid
//               req_data  [NREQ*DW]      requester i at [i*DW +: DW]
//               req_ready [NREQ]         one-hot grant (or zero)
//               out_valid/out_data/out_id/out_ready  result channel
//               conv_count [16], negzero_seen [1]
//                 (only when COMP_ARB_STATS_EN is defined)
// Macro       : COMP_ARB_STATS_EN - adds handshake counter and sticky
//               negative-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_conv_arb
    import comp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = c_dw,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready
`ifdef COMP_ARB_STATS_EN
    ,
    output logic [15:0]          conv_count,
    output logic [0:0]           negzero_seen
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [IDW-1:0] r_rr_ptr;
    logic [DW-1:0]  r_out_data;
    logic [IDW-1:0] r_out_id;

    logic           w_any_valid;
    logic [IDW-1:0] w_gnt_idx;
    int             w_cand;
    logic           w_can_accept;
    logic           w_grant;
    logic [DW-1:0]  w_sel_byte;
    logic [DW-1:0]  w_conv;

    // ------------------------------------------------------------------------
    // Round-robin search: first valid requester at or after r_rr_ptr,
    // wrapping cyclically upward.
    // ------------------------------------------------------------------------
    always_comb begin
        w_any_valid = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_any_valid && req_valid[w_cand]) begin
                w_any_valid = 1'b1;
                w_gnt_idx   = IDW'(w_cand);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: begin
                if (w_grant) begin
                    w_state_nxt = c_st_full;
                end
            end
            c_st_full: begin
                // A drain without a refill empties the register.
                if (out_ready && !w_grant) begin
                    w_state_nxt = c_st_empty;
                end
            end
            default: begin
                w_state_nxt = c_st_empty;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid    = (r_state == c_st_full);
        w_can_accept = (r_state == c_st_empty) || (out_ready && (r_state == c_st_full));
        // Gate with rst so no handshake completes while reset is asserted.
        w_grant      = w_can_accept && w_any_valid && !rst;
        req_ready    = '0;
        if (w_grant) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Grant mux feeding the shared converter
    // ------------------------------------------------------------------------
    assign w_sel_byte = req_data[w_gnt_idx*DW +: DW];

    sm2tc_unit #(
        .DW (DW)
    ) u_sm2tc (
        .i_sm (w_sel_byte),
        .o_tc (w_conv)
    );

    // ------------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_id   <= '0;
            r_rr_ptr   <= '0;
        end else if (w_grant) begin
            r_out_data <= w_conv;
            r_out_id   <= w_gnt_idx;
            r_rr_ptr   <= (w_gnt_idx == c_last_id) ? '0 : (w_gnt_idx + IDW'(1));
        end
    end

    assign out_data = r_out_data;
    assign out_id   = r_out_id;

`ifdef COMP_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics: output handshake counter (free-running wrap) and a sticky
    // flag recording that a negative-zero byte was ever granted.
    // ------------------------------------------------------------------------
    localparam logic [DW-1:0] c_neg_zero_dw = {1'b1, {(DW-1){1'b0}}};

    logic [15:0] r_conv_count;
    logic        r_negzero_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conv_count   <= '0;
            r_negzero_seen <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                r_conv_count <= r_conv_count + 16'd1;
            end
            if (w_grant && (w_sel_byte == c_neg_zero_dw)) begin
                r_negzero_seen <= 1'b1;
            end
        end
    end

    assign conv_count   = r_conv_count;
    assign negzero_seen = r_negzero_seen;
`endif

endmodule : comp_conv_arb
`default_nettype wire

// File: doc/comp_conv_arb.md
Name: comp_conv_arb

Overview:
- Round-robin arbiter/sequencer that shares one sign-magnitude to two's-complement converter among NREQ requesters.
- Each requester offers an 8-bit sign-magnitude byte over valid/ready. The winner's byte is converted and registered.
- The result is presented on one output channel with the requester ID, under downstream backpressure.
- Sits between the per-channel capture logic and the shared arithmetic path.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, ID width, equal to clog2(NREQ).
- DW, 8, data width: sign bit plus DW-1 magnitude bits.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  request i holds a valid byte.
- req_data  input  NREQ*DW  packed; requester i occupies bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot or zero; bit i high means request i is accepted this cycle.
- out_valid  output  1  out_data and out_id are valid.
- out_data  output  DW  converted two's-complement value.
- out_id  output  IDW  index of the requester the result belongs to.
- out_ready  input  1  downstream accepts the output this cycle.

Behaviour:
- Reset: out_valid=0, out_data=0, out_id=0, req_ready=0, rr_ptr=0, state=EMPTY. Reset applied mid-transfer discards the held result without completing it.
- Conversion (combinational, inside the sub-module):
  - If the sign bit is 0: pass the byte through unchanged.
  - If the sign bit is 1: result = {1, (~mag + 1) truncated to DW-1 bits}.
  - Boundary: 8'h80 -> 8'h80 (negative zero wraps); 8'hFF -> 8'h81; 8'h00 -> 8'h00.
- State machine (two states):
  - EMPTY: the output register holds nothing.
  - FULL: out_valid=1 and the register holds a result.
- Accept condition: `can_accept = (state==EMPTY) | (out_ready & out_valid)`.
  - When can_accept is true and any req_valid is set, grant the first valid requester at or after rr_ptr, searching cyclically upward.
- On a grant to requester g:
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - Next edge: out_data <= conv(req_data[g]), out_id <= g, out_valid <= 1, state <= FULL.
  - rr_ptr <= (g+1) mod NREQ.
- Latency: one cycle from accept to out_valid.
- Throughput: one result per cycle when out_ready stays high (drain and refill in the same cycle).
- FULL with out_ready=0: hold out_data, out_id and out_valid stable; req_ready=0 for all requesters.
- FULL with out_ready=1 and no req_valid: next state EMPTY, out_valid <= 0. out_data and out_id keep their last values.
- Requesters must hold req_data stable while req_valid=1 and req_ready=0. The block samples the byte only on the granting cycle.
- rr_ptr advances only on a grant. Wrap-around: a grant to requester NREQ-1 sets rr_ptr to 0.
- No requester is granted twice while another valid requester is waiting: starvation bound is NREQ grants.

Optional Feature:
- Macro: COMP_ARB_STATS_EN.
- Defined: adds output conv_count [15:0].
  - Reset 0; increments on every out_valid & out_ready handshake; wraps from 16'hFFFF to 0.
  - Adds output negzero_seen [0:0], a sticky flag set when a granted byte equals {1, DW-1 zeros}. Cleared only by rst.
- Undefined: neither port exists and no counter logic is instantiated. All other behaviour is identical.

Decomposition:
- Shared package comp_pkg holds:
  - The DW default (8).
  - The NEG_ZERO constant (8'h80).
  - A typedef sm_byte_t (logic [DW-1:0]).
  - A function clog2 used for IDW.
- One sub-module, sm2tc_unit: purely combinational DW-bit converter, one per block instance, fed by the grant mux.
- Arbitration, output register and the stats logic stay in comp_arb.

Test Plan:
- Single request: req_valid=0001, req0 byte=8'h85. Expect req_ready=0001 that cycle; next cycle out_valid=1, out_data=8'hFB, out_id=0.
- Boundary bytes through requester 2 with out_ready=1:
  - 8'h05 -> 8'h05
  - 8'h80 -> 8'h80
  - 8'hFF -> 8'h81
  - 8'h00 -> 8'h00
  - All with out_id=2.
- All four requesters valid continuously, out_ready=1. Expect grant order 0,1,2,3,0 on consecutive cycles, one result per cycle, rr_ptr wrapping 3 -> 0.
- Backpressure:
  - out_ready=0 for 5 cycles while out_valid=1: out_data and out_id stay stable and req_ready=0000.
  - Raise out_ready with req1 valid: drain and grant happen in the same cycle.
- Reset mid-operation: out_valid=1 and FULL, assert rst for 1 cycle. Next cycle out_valid=0, out_data=0, out_id=0, rr_ptr=0; the next grant goes to the lowest valid index.
- With COMP_ARB_STATS_EN defined: complete 3 handshakes including one byte of 8'h80. Expect conv_count=3 and negzero_seen=1; after rst both read 0.
